// File: rtl/handshake_const_check_pkg.sv
// Shared defaults for the constant-token generator/checker pair so both sides agree on the
// token value and statistics width.
package handshake_const_check_pkg;

  localparam int unsigned DefDataWidth = 37;
  localparam logic [DefDataWidth-1:0] DefConstValue = 37'b0100010010111111001100111101000011110;
  localparam int unsigned DefCntWidth = 16;

endpackage

// File: rtl/handshake_oslot_1.sv
// Generic one-slot elastic register: upstream may push whenever the slot is empty or is being
// drained in the same cycle. outs_ready -> in_ready is the only combinational path.
module handshake_oslot_1 #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  typedef enum logic [0:0] {StEmpty, StFull} slot_state_e;

  slot_state_e      state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StEmpty;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    in_ready = (state_q == StEmpty) | out_ready;
    case (state_q)
      StEmpty: begin
        if (in_valid) begin
          state_d = StFull;
          data_d  = in_data;
        end
      end
      StFull: begin
        if (out_ready) begin
          if (in_valid) data_d = in_data;
          else          state_d = StEmpty;
        end
      end
      default: state_d = StEmpty;
    endcase
  end

  assign out_valid = (state_q == StFull);
  assign out_data  = data_q;

endmodule

// File: rtl/handshake_const_check.sv
// Compares each accepted token with a compile-time constant, emits a 1-bit match token through
// a one-slot elastic register and keeps saturating token/mismatch statistics.
module handshake_const_check
  import handshake_const_check_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = DefDataWidth,
  parameter              CONST_VALUE = DefConstValue,
  parameter int unsigned CNT_WIDTH   = DefCntWidth
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] ins,
  input  logic                  ins_valid,
  output logic                  ins_ready,
  output logic                  outs,
  output logic                  outs_valid,
  input  logic                  outs_ready,
  input  logic                  cnt_clr,
  output logic [CNT_WIDTH-1:0]  tok_cnt,
  output logic [CNT_WIDTH-1:0]  mis_cnt,
  output logic                  mis_sticky
);

  // Untyped CONST_VALUE keeps the width of whatever literal is supplied, so a mismatch is caught.
  if ($bits(CONST_VALUE) != DATA_WIDTH) begin : g_const_width_err
    $error("handshake_const_check: CONST_VALUE width differs from DATA_WIDTH");
  end

  localparam logic [DATA_WIDTH-1:0] ExpValue = CONST_VALUE;
  localparam logic [CNT_WIDTH-1:0]  CntMax   = '1;
  localparam logic [CNT_WIDTH-1:0]  CntOne   = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic match;
  logic acc;

  assign match = (ins == ExpValue);
  assign acc   = ins_valid & ins_ready;

  handshake_oslot_1 #(
    .WIDTH (1)
  ) u_oslot (
    .clk       (clk),
    .rst       (rst),
    .in_data   (match),
    .in_valid  (ins_valid),
    .in_ready  (ins_ready),
    .out_data  (outs),
    .out_valid (outs_valid),
    .out_ready (outs_ready)
  );

  logic [CNT_WIDTH-1:0] tok_cnt_q, tok_cnt_d;
  logic [CNT_WIDTH-1:0] mis_cnt_q, mis_cnt_d;
  logic                 mis_sticky_q, mis_sticky_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tok_cnt_q    <= '0;
      mis_cnt_q    <= '0;
      mis_sticky_q <= 1'b0;
    end else begin
      tok_cnt_q    <= tok_cnt_d;
      mis_cnt_q    <= mis_cnt_d;
      mis_sticky_q <= mis_sticky_d;
    end
  end

  // Clear wipes history first; a coincident accept is then counted on top of the cleared state.
  always_comb begin
    tok_cnt_d    = tok_cnt_q;
    mis_cnt_d    = mis_cnt_q;
    mis_sticky_d = mis_sticky_q;
    if (cnt_clr) begin
      tok_cnt_d    = '0;
      mis_cnt_d    = '0;
      mis_sticky_d = 1'b0;
    end
    if (acc) begin
      if (tok_cnt_d != CntMax) tok_cnt_d = tok_cnt_d + CntOne;
      if (!match) begin
        if (mis_cnt_d != CntMax) mis_cnt_d = mis_cnt_d + CntOne;
        mis_sticky_d = 1'b1;
      end
    end
  end

  assign tok_cnt    = tok_cnt_q;
  assign mis_cnt    = mis_cnt_q;
  assign mis_sticky = mis_sticky_q;

endmodule
